// File: rtl/icache_sa_core.sv
// icache_sa_core: set-associative instruction-cache storage and control.
// Stage 1 captures the set index and snapshots tags, data and valid bits of
// every way; stage 2 compares the snapshot against the translated tag,
// tracks a single outstanding miss, takes the refill line, and handles
// hit/index invalidation plus a whole-cache flush sweep.
module icache_sa_core #(
  parameter int WAYS   = 2,
  parameter int SETS   = 64,
  parameter int TAG_W  = 20,
  parameter int LINE_W = 256,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [IDX_W-1:0]  index,
  input  logic              valid,
  input  logic [TAG_W-1:0]  tag1,
  output logic              hit,
  output logic [LINE_W-1:0] row,
  input  logic              rvalid,
  input  logic [LINE_W-1:0] rdata,
  input  logic              clear,
  input  logic              clearIdx,
  input  logic              flush_all,
  output logic              busy
);

  // Tree depth, way-number width and PLRU bits per set (tree of WAYS-1 nodes).
  localparam int LVL   = (WAYS > 1) ? $clog2(WAYS) : 0;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PW    = (WAYS > 1) ? WAYS - 1 : 1;

  typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

  // PLRU node n has children 2n+1 (left) and 2n+2 (right). A node bit of 0
  // points the victim search left, 1 points it right. The root decides the
  // way-number MSB.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PW-1:0] b);
    logic [WAY_W-1:0] w;
    int node;
    w    = '0;
    node = 0;
    for (int l = 0; l < LVL; l++) begin
      w[LVL-1-l] = b[node];
      node       = 2 * node + 1 + int'(b[node]);
    end
    return w;
  endfunction

  // Mark a way as most recently used: every node on its path points away.
  function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] b,
                                               input logic [WAY_W-1:0] w);
    logic [PW-1:0] r;
    logic          dir;
    int            node;
    r    = b;
    node = 0;
    for (int l = 0; l < LVL; l++) begin
      dir     = w[LVL-1-l];
      r[node] = ~dir;
      node    = 2 * node + 1 + int'(dir);
    end
    return r;
  endfunction

  // Flush sweep FSM and counter
  state_t             state_q, state_d;
  logic [IDX_W-1:0]   sweep_q, sweep_d;
  logic               sweeping;
  logic               idle;
  logic               flush_start;

  // Valid bits, stage-1 capture and snapshot
  logic [WAYS-1:0]    valid_q [SETS];
  logic [IDX_W-1:0]   idx_q;
  logic [WAYS-1:0]    snap_valid_q;
  logic               rd_en;

  // Stage-2 lookup results
  logic [WAYS-1:0]              way_hit;
  logic [WAYS-1:0][LINE_W-1:0]  snap_data;
  logic [WAY_W-1:0]             hit_way;
  logic [LINE_W-1:0]            hit_data;
  logic                         lookup_ok;
  logic                         miss;
  logic [LINE_W-1:0]            row_q;

  // Outstanding miss and victim choice
  logic               pend_q, pend_d;
  logic [IDX_W-1:0]   miss_idx_q, miss_idx_d;
  logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
  logic [WAY_W-1:0]   vict_q, vict_d;
  logic [WAY_W-1:0]   plru_pick;
  logic [WAY_W-1:0]   victim;
  logic               refill_en;

  // Invalidation
  logic               clr_en;
  logic [WAYS-1:0]    clr_mask;
  logic [WAYS-1:0]    vict_oh;
  logic [WAYS-1:0]    refill_row;

  // Sweep state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Sweep next state: start on flush_all when idle, stop after the last set
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (flush_all) state_d = ST_SWEEP;
      ST_SWEEP: if (sweep_q == IDX_W'(SETS - 1)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Sweep outputs; the counter advances only while sweeping and wraps to 0
  always_comb begin
    sweeping    = (state_q == ST_SWEEP);
    idle        = ~sweeping;
    busy        = sweeping;
    flush_start = flush_all & idle;
    sweep_d     = sweeping ? sweep_q + 1'b1 : '0;
  end

  assign rd_en     = req & idle;
  assign lookup_ok = valid & ~clear & idle;
  assign hit       = lookup_ok & (|way_hit);
  assign miss      = lookup_ok & ~(|way_hit);
  assign refill_en = rvalid & pend_q & idle;
  assign clr_en    = clear & idle;
  assign clr_mask  = clearIdx ? {WAYS{1'b1}} : way_hit;

  // Per-way tag and data storage with registered, read-first ports
  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [LINE_W-1:0] data_mem [SETS];
    logic [TAG_W-1:0]  rd_tag_q;
    logic [LINE_W-1:0] rd_data_q;
    logic              we;

    assign we = refill_en && (vict_q == WAY_W'(gi));

    // Snapshot on req; a refill in the same cycle lands for the next req
    always_ff @(posedge clk) begin
      if (rd_en) begin
        rd_tag_q  <= tag_mem[index];
        rd_data_q <= data_mem[index];
      end
      if (we) begin
        tag_mem[miss_idx_q]  <= miss_tag_q;
        data_mem[miss_idx_q] <= rdata;
      end
    end

    assign snap_data[gi] = rd_data_q;
    assign way_hit[gi]   = snap_valid_q[gi] && (rd_tag_q == tag1);
    assign vict_oh[gi]   = (vict_q == WAY_W'(gi));
  end

  // Select the hitting way; lowest way wins if several ever match
  always_comb begin
    hit_way  = '0;
    hit_data = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_hit[w]) begin
        hit_way  = WAY_W'(w);
        hit_data = snap_data[w];
      end
    end
  end

  // Victim: lowest invalid way of the snapshot, else the PLRU choice
  always_comb begin
    victim = plru_pick;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!snap_valid_q[w]) victim = WAY_W'(w);
    end
  end

  if (WAYS > 1) begin : g_plru
    logic [PW-1:0] plru_q [SETS];
    logic [PW-1:0] hit_touched;
    logic [PW-1:0] refill_base;

    assign plru_pick   = plru_victim(plru_q[idx_q]);
    assign hit_touched = plru_touch(plru_q[idx_q], hit_way);
    // A hit and a refill to the same set in one cycle both take effect
    assign refill_base = (hit && (idx_q == miss_idx_q)) ? hit_touched
                                                        : plru_q[miss_idx_q];

    // PLRU update on hit and refill; sweep and reset return sets to 0
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
      end else if (sweeping) begin
        plru_q[sweep_q] <= '0;
      end else begin
        if (hit)       plru_q[idx_q]      <= hit_touched;
        if (refill_en) plru_q[miss_idx_q] <= plru_touch(refill_base, vict_q);
      end
    end
  end else begin : g_no_plru
    assign plru_pick = '0;
  end

  // Refill sets its way after any same-cycle clear, so a pending refill
  // still completes into a set that was just invalidated
  always_comb begin
    refill_row = valid_q[miss_idx_q];
    if (clr_en && (idx_q == miss_idx_q)) refill_row = refill_row & ~clr_mask;
    refill_row = refill_row | vict_oh;
  end

  // Valid bits: sweep clears one set per cycle, otherwise clear then refill
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else if (sweeping) begin
      valid_q[sweep_q] <= '0;
    end else begin
      if (clr_en)    valid_q[idx_q]      <= valid_q[idx_q] & ~clr_mask;
      if (refill_en) valid_q[miss_idx_q] <= refill_row;
    end
  end

  // Stage-1 capture of index and valid snapshot; holds while req is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q        <= '0;
      snap_valid_q <= '0;
    end else if (rd_en) begin
      idx_q        <= index;
      snap_valid_q <= valid_q[index];
    end
  end

  // Miss tracking: refill retires it, a new miss re-latches, flush drops it
  always_comb begin
    pend_d     = pend_q;
    miss_idx_d = miss_idx_q;
    miss_tag_d = miss_tag_q;
    vict_d     = vict_q;
    if (refill_en) pend_d = 1'b0;
    if (miss) begin
      pend_d     = 1'b1;
      miss_idx_d = idx_q;
      miss_tag_d = tag1;
      vict_d     = victim;
    end
    if (flush_start) pend_d = 1'b0;
  end

  // Miss registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= 1'b0;
      miss_idx_q <= '0;
      miss_tag_q <= '0;
      vict_q     <= '0;
    end else begin
      pend_q     <= pend_d;
      miss_idx_q <= miss_idx_d;
      miss_tag_q <= miss_tag_d;
      vict_q     <= vict_d;
    end
  end

  // Row output holds the last hit line between hits
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      row_q <= '0;
    else if (hit) row_q <= hit_data;
  end

  assign row = hit ? hit_data : row_q;

endmodule
